// File: rtl/data_memory_storer.sv
// data_memory_storer: store path into a word-wide synchronous data memory
// without byte enables. Word stores issue a single write; byte and half
// stores read the target word, merge the new lane(s) and write it back.
//
// Optional build macro: MISALIGN_TRAP_EN
//   defined   - misaligned half/word requests raise a one-cycle fault_out
//               pulse instead of touching memory
//   undefined - misaligned requests are silently force-aligned
//
// state | meaning
// IDLE  | ready for a new request
// READ  | read strobe issued for the target word (sub-word stores)
// WAIT  | counting down READ_LATENCY; last cycle captures and merges
// WRITE | merged or full word written, done pulse
// FAULT | misaligned request rejected (MISALIGN_TRAP_EN only)

module data_memory_storer #(
  parameter int ADDR_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  req_valid_in,
  output logic                  req_ready_out,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [31:0]           data_in,
  input  logic [1:0]            size_in,
  output logic [ADDR_WIDTH-3:0] mem_addr_out,
  output logic                  mem_read_out,
  input  logic [31:0]           mem_rdata_in,
  output logic                  mem_write_out,
  output logic [31:0]           mem_wdata_out,
  output logic                  done_out
`ifdef MISALIGN_TRAP_EN
  ,
  output logic                  fault_out
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3
`ifdef MISALIGN_TRAP_EN
    ,
    FAULT = 3'd4
`endif
  } state_t;

  // Counter is wide enough for the largest supported latency (4).
  localparam logic [2:0] LAT_LOAD = 3'(READ_LATENCY);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-3:0] waddr_q, waddr_d;
  logic [1:0]            lane_q, lane_d;
  logic [15:0]           data_q, data_d;
  logic                  half_q, half_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [31:0]           merged;

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  // Half needs addr[0]=0; word (and size 10, which behaves as word) needs addr[1:0]=0.
  assign misaligned = ((size_in == 2'b01) && addr_in[0]) ||
                      (size_in[1] && (addr_in[1:0] != 2'b00));
`endif

  // Merge the captured store lane(s) into the word returned by memory.
  always_comb begin
    merged = mem_rdata_in;
    if (half_q) begin
      // addr[0] is ignored for halves, so only addr[1] picks the half.
      if (lane_q[1]) merged[31:16] = data_q;
      else           merged[15:0]  = data_q;
    end else begin
      merged[{lane_q, 3'b000} +: 8] = data_q[7:0];
    end
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    lane_d  = lane_q;
    data_d  = data_q;
    half_d  = half_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid_in) begin
`ifdef MISALIGN_TRAP_EN
          if (misaligned) begin
            state_d = FAULT;
          end else
`endif
          begin
            waddr_d = addr_in[ADDR_WIDTH-1:2];
            lane_d  = addr_in[1:0];
            data_d  = data_in[15:0];
            half_d  = (size_in == 2'b01);
            if (size_in[1]) begin
              wdata_d = data_in;
              state_d = WRITE;
            end else begin
              state_d = READ;
            end
          end
        end
      end
      READ: begin
        cnt_d   = LAT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 3'd1) begin
          wdata_d = merged;
          state_d = WRITE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      WRITE: state_d = IDLE;
`ifdef MISALIGN_TRAP_EN
      FAULT: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset; reset drops any partial request.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q <= IDLE;
      waddr_q <= '0;
      lane_q  <= '0;
      data_q  <= '0;
      half_q  <= 1'b0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      lane_q  <= lane_d;
      data_q  <= data_d;
      half_q  <= half_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready_out = (state_q == IDLE);
  assign mem_read_out  = (state_q == READ);
  assign mem_write_out = (state_q == WRITE);
  assign done_out      = (state_q == WRITE);
  assign mem_addr_out  = waddr_q;
  assign mem_wdata_out = wdata_q;
`ifdef MISALIGN_TRAP_EN
  assign fault_out     = (state_q == FAULT);
`endif

endmodule

// File: tb/tb_data_memory_storer.sv
// Bench for data_memory_storer: two instances (READ_LATENCY 1 and 3), each
// with a small latency-accurate memory model. Expected writes are queued when
// a request is driven and compared when the DUT issues its write strobe.

module tb_data_memory_storer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  typedef struct {
    logic [29:0] addr;
    logic [31:0] wdata;
    int          cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];

  // preload port shared by both memory models
  logic        pl_en = 1'b0;
  logic [7:0]  pl_a  = '0;
  logic [31:0] pl_d  = '0;

  // ---------------- DUT 1: READ_LATENCY = 1 ----------------
  logic        rst1, v1, rdy1, mrd1, mwr1, done1;
  logic [31:0] a1, d1, mrdata1, mwdata1;
  logic [1:0]  s1;
  logic [29:0] maddr1;
`ifdef MISALIGN_TRAP_EN
  logic        fault1;
`endif

  data_memory_storer #(.ADDR_WIDTH(32), .READ_LATENCY(1)) dut1 (
    .clock_in(clk), .reset_in(rst1), .req_valid_in(v1), .req_ready_out(rdy1),
    .addr_in(a1), .data_in(d1), .size_in(s1), .mem_addr_out(maddr1),
    .mem_read_out(mrd1), .mem_rdata_in(mrdata1), .mem_write_out(mwr1),
    .mem_wdata_out(mwdata1), .done_out(done1)
`ifdef MISALIGN_TRAP_EN
    , .fault_out(fault1)
`endif
  );

  logic [31:0] mem1 [0:255];
  logic [31:0] p1;
  logic        pv1 = 1'b0;
  always @(posedge clk) begin
    if (pl_en) mem1[pl_a] <= pl_d;
    if (mwr1)  mem1[maddr1[7:0]] <= mwdata1;
    pv1 <= mrd1;
    p1  <= mem1[maddr1[7:0]];
  end
  assign mrdata1 = pv1 ? p1 : 32'hBAD0_BAD0;

  // ---------------- DUT 3: READ_LATENCY = 3 ----------------
  logic        rst3, v3, rdy3, mrd3, mwr3, done3;
  logic [31:0] a3, d3, mrdata3, mwdata3;
  logic [1:0]  s3;
  logic [29:0] maddr3;
`ifdef MISALIGN_TRAP_EN
  logic        fault3;
`endif

  data_memory_storer #(.ADDR_WIDTH(32), .READ_LATENCY(3)) dut3 (
    .clock_in(clk), .reset_in(rst3), .req_valid_in(v3), .req_ready_out(rdy3),
    .addr_in(a3), .data_in(d3), .size_in(s3), .mem_addr_out(maddr3),
    .mem_read_out(mrd3), .mem_rdata_in(mrdata3), .mem_write_out(mwr3),
    .mem_wdata_out(mwdata3), .done_out(done3)
`ifdef MISALIGN_TRAP_EN
    , .fault_out(fault3)
`endif
  );

  logic [31:0] mem3 [0:255];
  logic [31:0] p3 [3];
  logic [2:0]  pv3 = '0;
  always @(posedge clk) begin
    if (pl_en) mem3[pl_a] <= pl_d;
    if (mwr3)  mem3[maddr3[7:0]] <= mwdata3;
    pv3   <= {pv3[1:0], mrd3};
    p3[0] <= mem3[maddr3[7:0]];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mrdata3 = pv3[2] ? p3[2] : 32'hBAD0_BAD0;

  // ---------------- write monitors ----------------
  always @(negedge clk) begin
    if (mwr1) begin
      exp_t e;
      check("wr1_done", {31'b0, done1}, 32'd1);
      check("wr1_expected", {31'b0, q1.size() != 0}, 32'd1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        check("wr1_addr", {2'b0, maddr1}, {2'b0, e.addr});
        check("wr1_data", mwdata1, e.wdata);
        check("wr1_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (mwr3) begin
      exp_t e;
      check("wr3_done", {31'b0, done3}, 32'd1);
      check("wr3_expected", {31'b0, q3.size() != 0}, 32'd1);
      if (q3.size() != 0) begin
        e = q3.pop_front();
        check("wr3_addr", {2'b0, maddr3}, {2'b0, e.addr});
        check("wr3_data", mwdata3, e.wdata);
        check("wr3_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic preload(input logic [7:0] wa, input logic [31:0] wd);
    @(negedge clk);
    pl_en = 1'b1; pl_a = wa; pl_d = wd;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // One store on DUT 1; lat is the expected accept-to-write distance.
  task automatic store1(input logic [31:0] addr, input logic [31:0] data,
                        input logic [1:0] size, input logic [31:0] exp_w, input int lat);
    exp_t e;
    @(negedge clk);
    check("ready_before", {31'b0, rdy1}, 32'd1);
    v1 = 1'b1; a1 = addr; d1 = data; s1 = size;
    e.addr = addr[31:2]; e.wdata = exp_w; e.cyc = cyc + lat;
    q1.push_back(e);
    @(negedge clk);
    v1 = 1'b0;
    check("read_strobe", {31'b0, mrd1}, {31'b0, lat > 1});
    check("ready_busy", {31'b0, rdy1}, 32'd0);
    check("addr_a1", {2'b0, maddr1}, {2'b0, addr[31:2]});
    for (int i = 0; i < 20 && q1.size() != 0; i++) @(negedge clk);
    check("write1_timeout", 32'(q1.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    rst1 = 1'b1; rst3 = 1'b1;
    v1 = 1'b0; a1 = '0; d1 = '0; s1 = '0;
    v3 = 1'b0; a3 = '0; d3 = '0; s3 = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, rdy1}, 32'd1);
    check("rst_read",  {31'b0, mrd1}, 32'd0);
    check("rst_write", {31'b0, mwr1}, 32'd0);
    check("rst_done",  {31'b0, done1}, 32'd0);
    check("rst_addr",  {2'b0, maddr1}, 32'd0);
    check("rst_wdata", mwdata1, 32'd0);
    check("rst3_ready", {31'b0, rdy3}, 32'd1);
`ifdef MISALIGN_TRAP_EN
    check("rst_fault", {31'b0, fault1}, 32'd0);
`endif
    rst1 = 1'b0; rst3 = 1'b0;

    preload(8'h40, 32'h1122_3344);
    store1(32'h102, 32'hAB, 2'b00, 32'h11AB_3344, 3);
    preload(8'h40, 32'h1122_3344);
    store1(32'h102, 32'hBEEF, 2'b01, 32'hBEEF_3344, 3);
    preload(8'h40, 32'h1122_3344);
    store1(32'h100, 32'hBEEF, 2'b01, 32'h1122_BEEF, 3);
    store1(32'h104, 32'hDEAD_BEEF, 2'b11, 32'hDEAD_BEEF, 1);
    preload(8'h41, 32'h0);
    store1(32'h104, 32'hDEAD_BEEF, 2'b10, 32'hDEAD_BEEF, 1);

    // reset during WAIT of a byte store: no write may follow
    preload(8'h40, 32'h1122_3344);
    @(negedge clk);
    v1 = 1'b1; a1 = 32'h102; d1 = 32'hCD; s1 = 2'b00;
    @(negedge clk);
    v1 = 1'b0;
    check("rstw_read", {31'b0, mrd1}, 32'd1);
    @(negedge clk);
    rst1 = 1'b1;
    @(negedge clk);
    check("rstw_ready", {31'b0, rdy1}, 32'd1);
    check("rstw_write", {31'b0, mwr1}, 32'd0);
    check("rstw_done",  {31'b0, done1}, 32'd0);
    check("rstw_addr",  {2'b0, maddr1}, 32'd0);
    check("rstw_wdata", mwdata1, 32'd0);
    rst1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rstw_no_write", {31'b0, mwr1}, 32'd0);
    end

    // misaligned half store
    preload(8'h40, 32'h1122_3344);
`ifdef MISALIGN_TRAP_EN
    @(negedge clk);
    v1 = 1'b1; a1 = 32'h101; d1 = 32'hBEEF; s1 = 2'b01;
    @(negedge clk);
    v1 = 1'b0;
    check("fault_pulse", {31'b0, fault1}, 32'd1);
    check("fault_read",  {31'b0, mrd1}, 32'd0);
    check("fault_write", {31'b0, mwr1}, 32'd0);
    check("fault_done",  {31'b0, done1}, 32'd0);
    @(negedge clk);
    check("fault_clear", {31'b0, fault1}, 32'd0);
    check("fault_ready", {31'b0, rdy1}, 32'd1);
    check("fault_noread", {31'b0, mrd1}, 32'd0);
`else
    store1(32'h101, 32'hBEEF, 2'b01, 32'h1122_BEEF, 3);
`endif

    // READ_LATENCY 3: byte to 0x103, second request held while busy
    preload(8'h40, 32'h0);
    @(negedge clk);
    check("l3_ready0", {31'b0, rdy3}, 32'd1);
    v3 = 1'b1; a3 = 32'h103; d3 = 32'h5A; s3 = 2'b00;
    e.addr = 30'h40; e.wdata = 32'h5A00_0000; e.cyc = cyc + 5;
    q3.push_back(e);
    e.addr = 30'h40; e.wdata = 32'h5A00_0077; e.cyc = cyc + 11;
    q3.push_back(e);
    @(negedge clk);
    a3 = 32'h100; d3 = 32'h77;
    check("l3_read", {31'b0, mrd3}, 32'd1);
    check("l3_ready", {31'b0, rdy3}, 32'd0);
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      check("l3_ready", {31'b0, rdy3}, 32'd0);
      check("l3_read_once", {31'b0, mrd3}, 32'd0);
    end
    @(negedge clk);
    check("l3_ready_a6", {31'b0, rdy3}, 32'd1);
    @(negedge clk);
    v3 = 1'b0;
    check("l3_second_read", {31'b0, mrd3}, 32'd1);
    for (int i = 0; i < 30 && q3.size() != 0; i++) @(negedge clk);
    check("write3_timeout", 32'(q3.size()), 32'd0);

    repeat (3) @(negedge clk);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
